// File: rtl/hippo_uart_loader.sv
// hippo_uart_loader
//   Receives 8N1 UART bytes and, once armed by start_i, writes them to
//   consecutive memory addresses starting at 0 until LOAD_LEN bytes are
//   written.
//
// Ports
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   rx_i        : UART receive line (asynchronous, idle high)
//   start_i     : arm / restart a load
//   addr_o      : memory write address
//   data_o      : memory write data
//   we_o        : single-cycle write strobe
//   busy_o      : load in progress
//   done_o      : LOAD_LEN bytes written, held until next start
//   frame_err_o : sticky stop-bit error, cleared by start
module hippo_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned LOAD_LEN     = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [7:0]            data_o,
  output logic                  we_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned NW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] LEN       = NW'(LOAD_LEN);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;

  rx_state_t       rx_state;
  ld_state_t       ld_state;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [NW-1:0]   count;
  logic [NW-1:0]   count_nxt;
  logic            rx_abort;
  logic            stop_tick;
  logic            byte_valid;
  logic            frame_bad;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // The stop-bit verdict is decoded combinationally so the write strobe can
  // be registered on the very edge that samples the stop bit.
  always_comb begin
    rx_abort   = start_i && (ld_state == L_LOAD);
    stop_tick  = (rx_state == R_STOP) && (clk_cnt == BIT_LAST);
    byte_valid = stop_tick && rx_s;
    frame_bad  = stop_tick && !rx_s;
    count_nxt  = count + NW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= R_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (rx_abort) begin
      rx_state <= R_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) begin
            rx_state <= R_START;
            bit_cnt  <= '0;
          end
        end
        R_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            rx_state <= rx_s ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= R_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        R_STOP: begin
          // Leave at the mid-bit sample so a following start bit is not missed.
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            rx_state <= R_IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_state    <= L_IDLE;
      addr_o      <= '0;
      data_o      <= '0;
      we_o        <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
      count       <= '0;
    end else begin
      if (frame_bad) frame_err_o <= 1'b1;
      case (ld_state)
        L_IDLE, L_DONE: begin
          if (start_i) begin
            ld_state    <= L_LOAD;
            addr_o      <= '0;
            count       <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
          end
        end
        L_LOAD: begin
          if (start_i) begin
            addr_o      <= '0;
            count       <= '0;
            we_o        <= 1'b0;
            frame_err_o <= 1'b0;
          end else if (we_o) begin
            // Advance only after the strobe so addr/data hold during it.
            we_o   <= 1'b0;
            addr_o <= addr_o + ADDR_WIDTH'(1);
            count  <= count_nxt;
            if (count_nxt == LEN) begin
              ld_state <= L_DONE;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
            end
          end else if (byte_valid) begin
            we_o   <= 1'b1;
            data_o <= shift;
          end
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hippo_uart_loader.sv
module tb_hippo_uart_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned LEN = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          rx_i;
  logic          start_i;
  logic [AW-1:0] addr_o;
  logic [7:0]    data_o;
  logic          we_o;
  logic          busy_o;
  logic          done_o;
  logic          frame_err_o;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa[$];
  logic [7:0]    wd[$];
  logic          prev_we = 1'b0;
  logic          snap_done = 1'b0;
  logic          snap_busy = 1'b1;
  int            wide_we = 0;

  hippo_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .LOAD_LEN    (LEN)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .start_i    (start_i),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .we_o       (we_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // Write logger: records every strobe and the flags one cycle after it.
  always @(negedge clk) begin
    if (we_o) begin
      wa.push_back(addr_o);
      wd.push_back(data_o);
      if (prev_we) wide_we <= wide_we + 1;
    end
    if (prev_we) begin
      snap_done <= done_o;
      snap_busy <= busy_o;
    end
    prev_we <= we_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      cycles(CPB);
    end
    rx_i = stop;
    cycles(CPB);
    rx_i = 1'b1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cycles(1);
    start_i = 1'b0;
  endtask

  initial begin
    rst_ni  = 1'b0;
    rx_i    = 1'b1;
    start_i = 1'b0;
    cycles(3);
    rst_ni = 1'b1;
    cycles(4);

    // Reset state
    chk("rst_addr", 32'(addr_o), 32'h0);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_we", 32'(we_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);

    // Byte while unarmed is dropped
    send_byte(8'h55, 1'b1);
    cycles(10);
    chk("unarmed_writes", 32'(wa.size()), 32'd0);

    // Full load
    wa.delete(); wd.delete();
    pulse_start();
    cycles(2);
    chk("load_busy", 32'(busy_o), 32'h1);
    send_byte(8'hA7, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    cycles(4);
    chk("load_count", 32'(wa.size()), 32'd4);
    if (wa.size() == 4) begin
      chk("load_a0", 32'(wa[0]), 32'd0);
      chk("load_d0", 32'(wd[0]), 32'hA7);
      chk("load_a1", 32'(wa[1]), 32'd1);
      chk("load_d1", 32'(wd[1]), 32'h00);
      chk("load_a2", 32'(wa[2]), 32'd2);
      chk("load_d2", 32'(wd[2]), 32'hFF);
      chk("load_a3", 32'(wa[3]), 32'd3);
      chk("load_d3", 32'(wd[3]), 32'h3C);
    end
    chk("done_after_last", 32'(snap_done), 32'h1);
    chk("busy_after_last", 32'(snap_busy), 32'h0);
    send_byte(8'h81, 1'b1);
    cycles(10);
    chk("fifth_dropped", 32'(wa.size()), 32'd4);
    chk("done_held", 32'(done_o), 32'h1);

    // Frame error
    wa.delete(); wd.delete();
    pulse_start();
    cycles(2);
    chk("restart_done_clr", 32'(done_o), 32'h0);
    send_byte(8'h12, 1'b0);
    cycles(16);
    chk("ferr_set", 32'(frame_err_o), 32'h1);
    send_byte(8'h34, 1'b1);
    cycles(10);
    chk("ferr_sticky", 32'(frame_err_o), 32'h1);
    chk("ferr_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("ferr_a", 32'(wa[0]), 32'd0);
      chk("ferr_d", 32'(wd[0]), 32'h34);
    end

    // Glitch
    wa.delete(); wd.delete();
    pulse_start();
    cycles(2);
    chk("start_clr_ferr", 32'(frame_err_o), 32'h0);
    rx_i = 1'b0;
    cycles(2);
    rx_i = 1'b1;
    cycles(30);
    chk("glitch_writes", 32'(wa.size()), 32'd0);
    chk("glitch_ferr", 32'(frame_err_o), 32'h0);
    chk("glitch_busy", 32'(busy_o), 32'h1);
    send_byte(8'h66, 1'b1);
    cycles(10);
    chk("post_glitch_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("post_glitch_a", 32'(wa[0]), 32'd0);
      chk("post_glitch_d", 32'(wd[0]), 32'h66);
    end

    // Abort / restart
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx_i = 1'b0;
    cycles(CPB);
    rx_i = 1'b1; cycles(CPB);
    rx_i = 1'b1; cycles(CPB);
    rx_i = 1'b0; cycles(CPB);
    rx_i = 1'b1;
    pulse_start();
    cycles(30);
    chk("abort_count", 32'(wa.size()), 32'd2);
    send_byte(8'h99, 1'b1);
    cycles(10);
    chk("abort_total", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("abort_a1", 32'(wa[1]), 32'd1);
      chk("abort_a2", 32'(wa[2]), 32'd0);
      chk("abort_d2", 32'(wd[2]), 32'h99);
    end
    chk("abort_done", 32'(done_o), 32'h0);
    chk("abort_addr", 32'(addr_o), 32'd1);

    // Asynchronous reset during bit 4
    wa.delete(); wd.delete();
    rx_i = 1'b0;
    cycles(CPB * 5 + 4);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_addr", 32'(addr_o), 32'h0);
    chk("arst_data", 32'(data_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_we", 32'(we_o), 32'h0);
    rx_i = 1'b1;
    cycles(3);
    rst_ni = 1'b1;
    cycles(100);
    chk("arst_no_write", 32'(wa.size()), 32'd0);
    pulse_start();
    send_byte(8'h5A, 1'b1);
    cycles(10);
    chk("arst_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("arst_a", 32'(wa[0]), 32'd0);
      chk("arst_d", 32'(wd[0]), 32'h5A);
    end

    chk("we_single_cycle", 32'(wide_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
